// File: rtl/vote_pkg.sv
// Shared types and constants for the voting-round controller and its tally.
// The state encoding and one-hot verdict codes are common to both modules.
package vote_pkg;

  localparam int N_VOTERS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } state_t;

  localparam logic [2:0] WIN  = 3'b100;
  localparam logic [2:0] TIE  = 3'b010;
  localparam logic [2:0] LOSE = 3'b001;

  function automatic logic [2:0] popcount4(input logic [N_VOTERS-1:0] bits);
    logic [2:0] acc;
    acc = 3'd0;
    for (int i = 0; i < N_VOTERS; i++) begin
      acc = acc + {2'b00, bits[i]};
    end
    return acc;
  endfunction

endpackage

// File: rtl/vote_tally.sv
// Combinational majority decoder: counts yes votes in the ballot and maps
// the count onto the one-hot {win, tie, lose} verdict.
module vote_tally
  import vote_pkg::*;
(
  input  logic [3:0] ballot,
  output logic [2:0] yes_cnt,
  output logic [2:0] verdict
);

  always_comb begin
    yes_cnt = popcount4(ballot);
    if (yes_cnt >= 3'd3) begin
      verdict = WIN;
    end else if (yes_cnt == 3'd2) begin
      verdict = TIE;
    end else begin
      verdict = LOSE;
    end
  end

endmodule

// File: rtl/vote_round_ctrl.sv
// Voting-round sequencer: opens a window on start, latches the first vote of
// each voter, closes on full ballot or timeout and registers the verdict.
module vote_round_ctrl
  import vote_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CW      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_vld,
  input  logic [3:0] vote_val,
  output logic       busy,
  output logic [3:0] voted,
  output logic [3:0] ballot,
  output logic [2:0] yes_cnt,
  output logic [2:0] verdict,
  output logic       timed_out,
  output logic       done
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [CW-1:0] timer_r;
  logic [3:0]  voted_r;
  logic [3:0]  ballot_r;
  logic [2:0]  yes_cnt_r;
  logic [2:0]  verdict_r;
  logic        timed_out_r;
  logic        done_r;
  logic        busy_r;

  logic        clear_s;
  logic        latch_s;
  logic        decide_s;
  logic        all_in_s;
  logic        tmo_s;
  logic [3:0]  new_mask_s;
  logic [2:0]  tally_cnt_s;
  logic [2:0]  tally_verdict_s;

  assign new_mask_s = vote_vld & ~voted_r;
  assign all_in_s   = ((voted_r | vote_vld) == 4'b1111);
  assign tmo_s      = (timer_r == CW'(TIMEOUT - 1));

  vote_tally u_tally (
    .ballot  (ballot_r),
    .yes_cnt (tally_cnt_s),
    .verdict (tally_verdict_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // A full ballot and the last timer cycle may coincide; either exits the same way.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (all_in_s || tmo_s) begin
          state_nxt_s = DECIDE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      DECIDE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  always_comb begin
    clear_s  = 1'b0;
    latch_s  = 1'b0;
    decide_s = 1'b0;
    case (state_r)
      IDLE: begin
        clear_s = start;
      end
      COLLECT: begin
        latch_s = 1'b1;
      end
      DECIDE: begin
        decide_s = 1'b1;
      end
      default: begin
        clear_s  = 1'b0;
        latch_s  = 1'b0;
        decide_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voted_r  <= 4'b0000;
      ballot_r <= 4'b0000;
      timer_r  <= '0;
    end else if (clear_s) begin
      voted_r  <= 4'b0000;
      ballot_r <= 4'b0000;
      timer_r  <= '0;
    end else if (latch_s) begin
      voted_r  <= voted_r | vote_vld;
      ballot_r <= ballot_r | (new_mask_s & vote_val);
      timer_r  <= timer_r + CW'(1);
    end
  end

  // Result registers hold their value between rounds; only DECIDE updates them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yes_cnt_r   <= 3'd0;
      verdict_r   <= LOSE;
      timed_out_r <= 1'b0;
    end else if (decide_s) begin
      yes_cnt_r   <= tally_cnt_s;
      verdict_r   <= tally_verdict_s;
      timed_out_r <= (voted_r != 4'b1111);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      done_r <= decide_s;
      busy_r <= (state_nxt_s != IDLE);
    end
  end

  assign busy      = busy_r;
  assign voted     = voted_r;
  assign ballot    = ballot_r;
  assign yes_cnt   = yes_cnt_r;
  assign verdict   = verdict_r;
  assign timed_out = timed_out_r;
  assign done      = done_r;

endmodule

// File: tb/tb_vote_round_ctrl.sv
// Directed bench for vote_round_ctrl: hand-computed expectations for each
// round type, checked with immediate assertions 1 ns after the clock edge.
module tb_vote_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] vote_vld;
  logic [3:0] vote_val;
  logic       busy;
  logic [3:0] voted;
  logic [3:0] ballot;
  logic [2:0] yes_cnt;
  logic [2:0] verdict;
  logic       timed_out;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  vote_round_ctrl #(.TIMEOUT(16), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vote_vld  (vote_vld),
    .vote_val  (vote_val),
    .busy      (busy),
    .voted     (voted),
    .ballot    (ballot),
    .yes_cnt   (yes_cnt),
    .verdict   (verdict),
    .timed_out (timed_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] vld, input logic [3:0] val);
    vote_vld = vld;
    vote_val = val;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result(input string tag, input logic d, input logic [2:0] v,
                            input logic [2:0] y, input logic t);
    chk({tag, "_done"}, {7'd0, done}, {7'd0, d});
    chk({tag, "_verdict"}, {5'd0, verdict}, {5'd0, v});
    chk({tag, "_yes_cnt"}, {5'd0, yes_cnt}, {5'd0, y});
    chk({tag, "_timed_out"}, {7'd0, timed_out}, {7'd0, t});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    vote_vld = 4'b0000;
    vote_val = 4'b0000;
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_voted", {4'd0, voted}, 8'd0);
    chk("rst_ballot", {4'd0, ballot}, 8'd0);
    chk_result("rst", 1'b0, 3'b001, 3'd0, 1'b0);
    rst = 1'b0;

    // Minimum round: all votes in the first COLLECT cycle
    start = 1'b1;
    step(4'b0000, 4'b0000);
    start = 1'b0;
    chk("a_busy", {7'd0, busy}, 8'd1);
    step(4'b1111, 4'b1011);
    chk("a_voted", {4'd0, voted}, 8'h0f);
    chk("a_ballot", {4'd0, ballot}, 8'h0b);
    chk("a_nodone", {7'd0, done}, 8'd0);
    step(4'b0000, 4'b0000);
    chk_result("a", 1'b1, 3'b100, 3'd3, 1'b0);
    chk("a_busy_end", {7'd0, busy}, 8'd0);
    step(4'b0000, 4'b0000);
    chk("a_done_pulse", {7'd0, done}, 8'd0);
    chk("a_verdict_hold", {5'd0, verdict}, 8'h04);

    // Staggered votes, with a start pulse inside COLLECT
    start = 1'b1;
    step(4'b0000, 4'b0000);
    start = 1'b0;
    step(4'b0001, 4'b0001);
    chk("b_voted1", {4'd0, voted}, 8'h01);
    start = 1'b1;
    step(4'b0010, 4'b0010);
    start = 1'b0;
    chk("b_start_ignored_busy", {7'd0, busy}, 8'd1);
    chk("b_start_ignored_voted", {4'd0, voted}, 8'h03);
    step(4'b0100, 4'b0000);
    step(4'b1000, 4'b0000);
    step(4'b0000, 4'b0000);
    chk_result("b", 1'b1, 3'b010, 3'd2, 1'b0);
    chk("b_ballot", {4'd0, ballot}, 8'h03);

    // Votes in IDLE are dropped
    step(4'b1111, 4'b1111);
    chk("idle_voted", {4'd0, voted}, 8'h0f);
    chk("idle_ballot", {4'd0, ballot}, 8'h03);
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // Duplicate vote: the first value wins
    start = 1'b1;
    step(4'b0000, 4'b0000);
    start = 1'b0;
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0000);
    chk("c_dup_ballot", {4'd0, ballot}, 8'h04);
    step(4'b1011, 4'b0000);
    chk("c_ballot", {4'd0, ballot}, 8'h04);
    step(4'b0000, 4'b0000);
    chk_result("c", 1'b1, 3'b001, 3'd1, 1'b0);

    // Timeout round: done 18 cycles after start
    start = 1'b1;
    step(4'b0000, 4'b0000);
    start = 1'b0;
    step(4'b0001, 4'b0001);
    for (int i = 0; i < 15; i++) step(4'b0000, 4'b0000);
    chk("d_early_done", {7'd0, done}, 8'd0);
    chk("d_decide_busy", {7'd0, busy}, 8'd1);
    step(4'b0000, 4'b0000);
    chk_result("d", 1'b1, 3'b001, 3'd1, 1'b1);
    chk("d_ballot", {4'd0, ballot}, 8'h01);

    // Final vote on the timer's last cycle
    start = 1'b1;
    step(4'b0000, 4'b0000);
    start = 1'b0;
    step(4'b0111, 4'b0111);
    for (int i = 0; i < 14; i++) step(4'b0000, 4'b0000);
    chk("e_last_busy", {7'd0, busy}, 8'd1);
    chk("e_last_voted", {4'd0, voted}, 8'h07);
    step(4'b1000, 4'b1000);
    chk("e_voted", {4'd0, voted}, 8'h0f);
    step(4'b0000, 4'b0000);
    chk_result("e", 1'b1, 3'b100, 3'd4, 1'b0);

    // start held high re-arms right after done
    start = 1'b1;
    step(4'b0000, 4'b0000);
    step(4'b1111, 4'b0000);
    step(4'b0000, 4'b0000);
    chk_result("f", 1'b1, 3'b001, 3'd0, 1'b0);
    step(4'b0000, 4'b0000);
    start = 1'b0;
    chk("f_rearm_busy", {7'd0, busy}, 8'd1);
    chk("f_rearm_voted", {4'd0, voted}, 8'h00);

    // Mid-round reset aborts at once
    step(4'b0011, 4'b0011);
    chk("g_voted", {4'd0, voted}, 8'h03);
    rst = 1'b1;
    #1;
    chk("g_rst_busy", {7'd0, busy}, 8'd0);
    chk("g_rst_voted", {4'd0, voted}, 8'h00);
    chk("g_rst_ballot", {4'd0, ballot}, 8'h00);
    chk_result("g_rst", 1'b0, 3'b001, 3'd0, 1'b0);
    step(4'b0000, 4'b0000);
    chk("g_rst_nodone", {7'd0, done}, 8'd0);
    rst = 1'b0;
    step(4'b0000, 4'b0000);
    chk("g_idle_done", {7'd0, done}, 8'd0);

    // Clean round after reset
    start = 1'b1;
    step(4'b0000, 4'b0000);
    start = 1'b0;
    step(4'b1111, 4'b1100);
    step(4'b0000, 4'b0000);
    chk_result("h", 1'b1, 3'b010, 3'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vote_round_ctrl.md
# vote_round_ctrl

Sequencer for one voting round of the win-or-tail decision machine. Opens a voting window on `start`, latches at most one vote per voter from four independent requesters, and closes the window when all four have voted or a timeout expires. It then presents the assembled 4-bit ballot to the combinational majority decoder and registers a one-hot verdict with a `done` pulse. The block sits between the voter input pads and the result display logic.

## Interface
- `TIMEOUT`, 16: maximum COLLECT cycles per round; legal range 2..255.
- `CW`, 8: timer width; must satisfy `TIMEOUT` ≤ 2^`CW`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  open a round; honoured only in IDLE.
- `vote_vld`  in  4  per-voter strobe; bit i means voter i is presenting a vote this cycle.
- `vote_val`  in  4  per-voter value; 1 = yes, 0 = no; qualified by `vote_vld[i]`.
- `busy`  out  1  high in COLLECT and DECIDE.
- `voted`  out  4  mask of voters already latched this round.
- `ballot`  out  4  latched vote values; absent voters read 0.
- `yes_cnt`  out  3  popcount of `ballot`, registered with the verdict.
- `verdict`  out  3  one-hot `{win, tie, lose}`, registered.
- `timed_out`  out  1  set when the round closed by timeout with fewer than 4 votes.
- `done`  out  1  single-cycle pulse; verdict valid from this cycle on.

## Operation
- States: IDLE, COLLECT, DECIDE.
- IDLE:
  - `start` = 1 → COLLECT.
  - On that transition, clear `voted`, `ballot` and the timer. `verdict`, `yes_cnt` and `timed_out` keep their old values until the next DECIDE.
- COLLECT:
  - For each i with `vote_vld[i]` = 1 and `voted[i]` = 0: set `voted[i]` and `ballot[i]` ← `vote_val[i]`.
  - Repeat votes from a voter already latched are ignored; the first vote wins.
  - Timer increments every COLLECT cycle.
  - Go to DECIDE when the next-state mask `voted | vote_vld` = 4'b1111, or when timer = `TIMEOUT`-1. Whichever fires first wins; if both fire in the same cycle, the exit is not a timeout.
  - Votes presented in the exiting cycle are latched.
- DECIDE, one cycle:
  - Register `yes_cnt`.
  - `verdict` = win if `yes_cnt` ≥ 3, tie if = 2, lose if ≤ 1.
  - `timed_out` = (`voted` ≠ 4'b1111).
  - `done` is registered for the following cycle; next state is IDLE.
- `start` outside IDLE is ignored. `start` held high re-arms a new round in the cycle after `done`.
- Votes arriving in IDLE or DECIDE are dropped.
- Absent voters count as "no".

## Timing
- Reset values: state IDLE; `busy` 0; `voted` 0000; `ballot` 0000; `yes_cnt` 0; `verdict` 3'b001 (lose); `timed_out` 0; `done` 0; timer 0.
- Reset asserted mid-round aborts immediately to IDLE with all reset values and no `done`.
- `start` sampled at edge T:
  - COLLECT from T+1.
  - All four votes at edge T+k (k ≥ 1) → DECIDE at T+k+1.
  - `done` = 1 and `verdict` valid in the cycle after edge T+k+2.
- Minimum round (all votes in the first COLLECT cycle): `done` 3 cycles after `start`.
- Timeout round: `TIMEOUT` COLLECT cycles, then DECIDE; `done` at `start` + `TIMEOUT` + 2.
- `done` lasts exactly 1 cycle.
- `verdict`, `yes_cnt` and `timed_out` are stable from `done` until the next DECIDE.

## Structure
- Package `vote_pkg`:
  - state enum (IDLE = 2'd0, COLLECT = 2'd1, DECIDE = 2'd2)
  - verdict encodings WIN = 3'b100, TIE = 3'b010, LOSE = 3'b001
  - `N_VOTERS` = 4
- Sub-module `vote_tally`: purely combinational, 4-bit ballot in → 3-bit popcount and one-hot verdict out. Instantiated once and registered by the controller in DECIDE.
- The remainder (FSM, timer, vote latch) lives in the top module.

## Test plan
- Reset → all outputs at reset values. Then `start`, then `vote_vld` = 1111 and `vote_val` = 1011 in the first COLLECT cycle → `done` 3 cycles after `start`; `verdict` = 100, `yes_cnt` = 3, `timed_out` = 0.
- Votes staggered one per cycle: voter0 = 1, voter1 = 1, voter2 = 0, voter3 = 0 → `verdict` = 010 (tie), `yes_cnt` = 2.
- Duplicate vote: voter2 votes 1 and later votes 0, others 0 → `ballot` = 0100, `verdict` = 001.
- Timeout (`TIMEOUT` = 16): only voter0 votes 1 → `done` at `start` + 18; `timed_out` = 1; `ballot` = 0001; `verdict` = 001.
- Edge cases:
  - `start` pulsed during COLLECT → no effect.
  - Votes in IDLE → dropped.
  - Final vote on the timer's last cycle → latched, `timed_out` = 0.
- `rst` asserted in mid-COLLECT with `voted` = 0011 → immediate return to reset values, no `done`. Next `start` runs a clean round.
